vdp_cpu_port: RTL

//  CPU-side port of the TMS9918-style VDP: the writer/controller end of the VRAM and register

---
 rtl/vdp_cpu_port_pkg.sv | 29 ++
 rtl/vdp_cpu_port_regfile.sv | 71 +++++++
 rtl/vdp_cpu_port.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/vdp_cpu_port_pkg.sv
// Shared definitions for the VDP CPU port: register indices, display modes and
// the prefetch FSM state type.
package vdp_cpu_port_pkg;

  localparam logic [2:0] REG_MODE0   = 3'd0;
  localparam logic [2:0] REG_MODE1   = 3'd1;
  localparam logic [2:0] REG_NAME    = 3'd2;
  localparam logic [2:0] REG_COLOR   = 3'd3;
  localparam logic [2:0] REG_FONT    = 3'd4;
  localparam logic [2:0] REG_SATTR   = 3'd5;
  localparam logic [2:0] REG_SPAT    = 3'd6;
  localparam logic [2:0] REG_COLOURS = 3'd7;

  localparam logic [1:0] MODE_TEXT = 2'd0;
  localparam logic [1:0] MODE_G1   = 2'd1;
  localparam logic [1:0] MODE_G2   = 2'd2;
  localparam logic [1:0] MODE_MC   = 2'd3;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} pf_state_e;

  // M1 (text) dominates, then M3, then M2; no mode bit selects graphics I.
  function automatic logic [1:0] decode_mode(input logic m1, input logic m2, input logic m3);
    if (m1) return MODE_TEXT;
    if (m3) return MODE_G2;
    if (m2) return MODE_MC;
    return MODE_G1;
  endfunction

endpackage

// File: rtl/vdp_cpu_port_regfile.sv
// VDP control registers R0-R7 (only the bits the display block consumes are
// stored) and their decoded table bases, mode and colours.
module vdp_cpu_port_regfile
  import vdp_cpu_port_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [2:0]  i_idx,
  input  logic [7:0]  i_wdata,
  output logic [1:0]  o_mode,
  output logic        o_video_on,
  output logic        o_int_en,
  output logic        o_sprite_large,
  output logic        o_sprite_enlarged,
  output logic [13:0] o_name_table_addr,
  output logic [13:0] o_color_table_addr,
  output logic [13:0] o_font_addr,
  output logic [13:0] o_sprite_attr_addr,
  output logic [13:0] o_sprite_pattern_table_addr,
  output logic [3:0]  o_text_color,
  output logic [3:0]  o_back_color
);

  logic       r_m3;
  logic [5:0] r_r1;  // {blank, ie, m1, m2, size, mag}
  logic [3:0] r_r2;
  logic [7:0] r_r3;
  logic [2:0] r_r4;
  logic [6:0] r_r5;
  logic [2:0] r_r6;
  logic [7:0] r_r7;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_m3 <= 1'b0;
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
      r_r4 <= '0;
      r_r5 <= '0;
      r_r6 <= '0;
      r_r7 <= '0;
    end else if (i_we) begin
      unique case (i_idx)
        REG_MODE0:   r_m3 <= i_wdata[1];
        REG_MODE1:   r_r1 <= {i_wdata[6:3], i_wdata[1:0]};
        REG_NAME:    r_r2 <= i_wdata[3:0];
        REG_COLOR:   r_r3 <= i_wdata;
        REG_FONT:    r_r4 <= i_wdata[2:0];
        REG_SATTR:   r_r5 <= i_wdata[6:0];
        REG_SPAT:    r_r6 <= i_wdata[2:0];
        REG_COLOURS: r_r7 <= i_wdata;
      endcase
    end
  end

  assign o_mode                      = decode_mode(r_r1[3], r_r1[2], r_m3);
  assign o_video_on                  = r_r1[5];
  assign o_int_en                    = r_r1[4];
  assign o_sprite_large              = r_r1[1];
  assign o_sprite_enlarged           = r_r1[0];
  assign o_name_table_addr           = {r_r2, 10'b0};
  assign o_color_table_addr          = {r_r3, 6'b0};
  assign o_font_addr                 = {r_r4, 11'b0};
  assign o_sprite_attr_addr          = {r_r5, 7'b0};
  assign o_sprite_pattern_table_addr = {r_r6, 11'b0};
  assign o_text_color                = r_r7[7:4];
  assign o_back_color                = r_r7[3:0];

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU side of a TMS9918-style VDP: decodes data/control port accesses, drives
// VRAM with auto-increment and read-ahead, and holds status and interrupt.
module vdp_cpu_port
  import vdp_cpu_port_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_wr,
  input  logic              i_cpu_rd,
  input  logic              i_cpu_a0,
  input  logic [7:0]        i_cpu_din,
  output logic [7:0]        o_cpu_dout,
  output logic              o_cpu_wait,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic [7:0]        o_vram_wdata,
  input  logic [7:0]        i_vram_rdata,
  output logic              o_vram_wr,
  output logic              o_vram_rd,
  input  logic              i_vblank,
  input  logic              i_spr_coll,
  input  logic              i_spr_5th,
  input  logic [4:0]        i_spr_5num,
  output logic [1:0]        o_mode,
  output logic              o_video_on,
  output logic              o_sprite_large,
  output logic              o_sprite_enlarged,
  output logic [13:0]       o_name_table_addr,
  output logic [13:0]       o_color_table_addr,
  output logic [13:0]       o_font_addr,
  output logic [13:0]       o_sprite_attr_addr,
  output logic [13:0]       o_sprite_pattern_table_addr,
  output logic [3:0]        o_text_color,
  output logic [3:0]        o_back_color,
  output logic              o_n_int
);

  pf_state_e         r_state;
  logic [1:0]        r_wait_cnt;
  logic              r_flag;
  logic [7:0]        r_latch;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_buffer;
  logic [7:0]        r_cpu_dout;
  logic              r_cpu_wait;
  logic [ADDR_W-1:0] r_vram_addr;
  logic [7:0]        r_vram_wdata;
  logic              r_vram_wr;
  logic              r_vram_rd;
  logic              r_f;
  logic              r_c;
  logic              r_5s;
  logic [4:0]        r_5num;
  logic              r_n_int;

  logic              w_idle;
  logic              w_wr;
  logic              w_rd;
  logic              w_ctrl_wr;
  logic              w_data_wr;
  logic              w_data_rd;
  logic              w_stat_rd;
  logic              w_reg_we;
  logic              w_addr_ld;
  logic              w_pf_start;
  logic              w_int_en;
  logic [13:0]       w_addr_setup;
  logic [ADDR_W-1:0] w_addr_new;
  logic [ADDR_W-1:0] w_pf_addr;

  // Strobes arriving while a prefetch is in flight are dropped; write beats read.
  assign w_idle       = (r_state == StIdle);
  assign w_wr         = i_cpu_wr & w_idle;
  assign w_rd         = i_cpu_rd & ~i_cpu_wr & w_idle;
  assign w_ctrl_wr    = w_wr & i_cpu_a0;
  assign w_data_wr    = w_wr & ~i_cpu_a0;
  assign w_data_rd    = w_rd & ~i_cpu_a0;
  assign w_stat_rd    = w_rd & i_cpu_a0;
  assign w_reg_we     = w_ctrl_wr & r_flag & i_cpu_din[7];
  assign w_addr_ld    = w_ctrl_wr & r_flag & ~i_cpu_din[7];
  assign w_pf_start   = (w_addr_ld & ~i_cpu_din[6]) | w_data_rd;
  assign w_addr_setup = {i_cpu_din[5:0], r_latch};
  assign w_addr_new   = w_addr_setup[ADDR_W-1:0];
  assign w_pf_addr    = w_addr_ld ? w_addr_new : r_addr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_wait_cnt   <= '0;
      r_flag       <= 1'b0;
      r_latch      <= '0;
      r_addr       <= '0;
      r_buffer     <= '0;
      r_cpu_dout   <= '0;
      r_cpu_wait   <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
      r_vram_wr    <= 1'b0;
      r_vram_rd    <= 1'b0;
      r_f          <= 1'b0;
      r_c          <= 1'b0;
      r_5s         <= 1'b0;
      r_5num       <= '0;
      r_n_int      <= 1'b1;
    end else begin
      r_vram_wr <= 1'b0;
      r_vram_rd <= 1'b0;
      r_n_int   <= ~(r_f & w_int_en);

      if (w_ctrl_wr) begin
        r_flag <= ~r_flag;
        if (!r_flag) r_latch <= i_cpu_din;
      end else if (w_data_wr || w_rd) begin
        r_flag <= 1'b0;
      end

      if (w_addr_ld) r_addr <= w_addr_new;

      if (w_data_wr) begin
        r_vram_wr    <= 1'b1;
        r_vram_addr  <= r_addr;
        r_vram_wdata <= i_cpu_din;
        r_buffer     <= i_cpu_din;
        r_addr       <= r_addr + 1'b1;
      end

      if (w_data_rd) r_cpu_dout <= r_buffer;
      if (w_stat_rd) begin
        r_cpu_dout <= {r_f, r_5s, r_c, r_5num};
        r_f        <= 1'b0;
        r_5s       <= 1'b0;
        r_c        <= 1'b0;
      end
      // Incoming events override the read-clear above.
      if (i_vblank)   r_f <= 1'b1;
      if (i_spr_coll) r_c <= 1'b1;
      if (i_spr_5th) begin
        r_5s   <= 1'b1;
        r_5num <= i_spr_5num;
      end

      case (r_state)
        StIdle: begin
          if (w_pf_start) begin
            r_state     <= StIssue;
            r_vram_rd   <= 1'b1;
            r_vram_addr <= w_pf_addr;
            r_cpu_wait  <= 1'b1;
          end
        end
        StIssue: begin
          if (RD_LATENCY > 1) begin
            r_state    <= StWait;
            r_wait_cnt <= 2'(RD_LATENCY - 2);
          end else begin
            r_state <= StCapture;
          end
        end
        StWait: begin
          if (r_wait_cnt == 2'd0) r_state <= StCapture;
          else r_wait_cnt <= r_wait_cnt - 2'd1;
        end
        StCapture: begin
          r_buffer   <= i_vram_rdata;
          r_addr     <= r_addr + 1'b1;
          r_state    <= StIdle;
          r_cpu_wait <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  vdp_cpu_port_regfile u_regfile (
    .i_clk                       (i_clk),
    .i_reset                     (i_reset),
    .i_we                        (w_reg_we),
    .i_idx                       (i_cpu_din[2:0]),
    .i_wdata                     (r_latch),
    .o_mode                      (o_mode),
    .o_video_on                  (o_video_on),
    .o_int_en                    (w_int_en),
    .o_sprite_large              (o_sprite_large),
    .o_sprite_enlarged           (o_sprite_enlarged),
    .o_name_table_addr           (o_name_table_addr),
    .o_color_table_addr          (o_color_table_addr),
    .o_font_addr                 (o_font_addr),
    .o_sprite_attr_addr          (o_sprite_attr_addr),
    .o_sprite_pattern_table_addr (o_sprite_pattern_table_addr),
    .o_text_color                (o_text_color),
    .o_back_color                (o_back_color)
  );

  assign o_cpu_dout   = r_cpu_dout;
  assign o_cpu_wait   = r_cpu_wait;
  assign o_vram_addr  = r_vram_addr;
  assign o_vram_wdata = r_vram_wdata;
  assign o_vram_wr    = r_vram_wr;
  assign o_vram_rd    = r_vram_rd;
  assign o_n_int      = r_n_int;

endmodule
